seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with a double-buffered display image.
// New data is staged in a pending register and only becomes visible at a frame boundary.
module seg7_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int BLANK   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  en_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pcnt_reg;
  logic [2:0]    idx_reg;
  logic [31:0]   act_data_reg, pend_data_reg;
  logic [7:0]    act_en_reg, pend_en_reg;
  logic          pending_reg, frame_done_reg;
  logic [6:0]    seg_reg;
  logic [7:0]    an_reg;

  logic          tick, wrap, in_blank, digit_off;
  logic [3:0]    nib [8];
  logic [3:0]    cur_nib;
  logic [6:0]    seg_next;

  assign tick = (pcnt_reg == PCNT_MAX);
  assign wrap = tick && (idx_reg == 3'd7);

  // A zero-length blank window must not generate an always-false compare.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [PW-1:0] BLANK_W = PW'(BLANK);
      assign in_blank = (pcnt_reg < BLANK_W);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib[gi] = act_data_reg[4*gi +: 4];
    end
  endgenerate

  assign cur_nib   = nib[idx_reg];
  assign digit_off = in_blank || !act_en_reg[idx_reg];

  always_comb begin
    seg_next = 7'h7F;
    case (cur_nib)
      4'h0: seg_next = 7'h01;
      4'h1: seg_next = 7'h4F;
      4'h2: seg_next = 7'h12;
      4'h3: seg_next = 7'h06;
      4'h4: seg_next = 7'h4C;
      4'h5: seg_next = 7'h24;
      4'h6: seg_next = 7'h20;
      4'h7: seg_next = 7'h0F;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h04;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h60;
      4'hC: seg_next = 7'h31;
      4'hD: seg_next = 7'h42;
      4'hE: seg_next = 7'h30;
      4'hF: seg_next = 7'h38;
      default: seg_next = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg       <= '0;
      idx_reg        <= 3'd0;
      frame_done_reg <= 1'b0;
    end else begin
      if (tick) begin
        pcnt_reg <= '0;
        idx_reg  <= idx_reg + 3'd1;
      end else begin
        pcnt_reg <= pcnt_reg + PW'(1);
      end
      frame_done_reg <= wrap;
    end
  end

  // A load landing on the wrap edge bypasses staging so it is shown next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data_reg  <= '0;
      act_en_reg    <= '0;
      pend_data_reg <= '0;
      pend_en_reg   <= '0;
      pending_reg   <= 1'b0;
    end else if (load && wrap) begin
      act_data_reg <= data_in;
      act_en_reg   <= en_in;
      pending_reg  <= 1'b0;
    end else if (load) begin
      pend_data_reg <= data_in;
      pend_en_reg   <= en_in;
      pending_reg   <= 1'b1;
    end else if (wrap && pending_reg) begin
      act_data_reg <= pend_data_reg;
      act_en_reg   <= pend_en_reg;
      pending_reg  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
    end else if (digit_off) begin
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
    end else begin
      an_reg  <= ~(8'h01 << idx_reg);
      seg_reg <= seg_next;
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign pending    = pending_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for two scanner configurations (CLK_DIV=4/BLANK=1 and CLK_DIV=2/BLANK=0)
// driven with identical stimulus; expectations come from a cycle-count based display model.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data_in = '0;
  logic [7:0]  en_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg_a, seg_b;
  logic [7:0]  an_a, an_b;
  logic        pend_a, pend_b, fd_a, fd_b;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.CLK_DIV(4), .BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .en_in(en_in), .load(load),
    .seg(seg_a), .an(an_a), .pending(pend_a), .frame_done(fd_a)
  );

  seg7_scan_ctrl #(.CLK_DIV(2), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .en_in(en_in), .load(load),
    .seg(seg_b), .an(an_b), .pending(pend_b), .frame_done(fd_b)
  );

  typedef struct packed {
    logic [1:0][7:0] an;
    logic [1:0][6:0] seg;
    logic [1:0]      fd;
    logic [1:0]      pd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [6:0]  seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  logic [31:0] m_act_d [2];
  logic [31:0] m_pnd_d [2];
  logic [7:0]  m_act_e [2];
  logic [7:0]  m_pnd_e [2];
  logic        m_pnd   [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act_d[i] = '0; m_act_e[i] = '0;
      m_pnd_d[i] = '0; m_pnd_e[i] = '0;
      m_pnd[i]   = 1'b0;
    end
    cyc = 0;
  endtask

  // Predict the outputs visible just after the coming rising edge, then advance the model.
  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] e);
    exp_t x;
    int   cd, bl, pc, id;
    logic wr;
    @(negedge clk);
    rst_n = 1'b1; load = ld; data_in = d; en_in = e;
    for (int i = 0; i < 2; i++) begin
      cd = (i == 0) ? 4 : 2;
      bl = (i == 0) ? 1 : 0;
      pc = cyc % cd;
      id = (cyc / cd) % 8;
      wr = ((cyc % (8 * cd)) == 8 * cd - 1);
      if (pc < bl || !m_act_e[i][id]) begin
        x.an[i]  = 8'hFF;
        x.seg[i] = 7'h7F;
      end else begin
        x.an[i]  = ~(8'h01 << id);
        x.seg[i] = seg_tbl[m_act_d[i][4*id +: 4]];
      end
      x.fd[i] = wr;
      if (ld && wr) begin
        m_act_d[i] = d; m_act_e[i] = e; m_pnd[i] = 1'b0;
      end else if (ld) begin
        m_pnd_d[i] = d; m_pnd_e[i] = e; m_pnd[i] = 1'b1;
      end else if (wr && m_pnd[i]) begin
        m_act_d[i] = m_pnd_d[i]; m_act_e[i] = m_pnd_e[i]; m_pnd[i] = 1'b0;
      end
      x.pd[i] = m_pnd[i];
    end
    if (ld) $display("load cycle=%0d data=%h en=%h", cyc, d, e);
    cyc++;
    q.push_back(x);
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(1'b0, $urandom, 8'($urandom));
  endtask

  task automatic idle_until(input int phase);
    while (cyc % 32 != phase) step(1'b0, $urandom, 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_an_a", 32'(an_a), 32'hFF);
    check("rst_seg_a", 32'(seg_a), 32'h7F);
    check("rst_pend_a", 32'(pend_a), 32'h0);
    check("rst_fd_a", 32'(fd_a), 32'h0);
    check("rst_an_b", 32'(an_b), 32'hFF);
    check("rst_seg_b", 32'(seg_b), 32'h7F);
    check("rst_pend_b", 32'(pend_b), 32'h0);
    check("rst_fd_b", 32'(fd_b), 32'h0);
    $display("reset asserted t=%0t", $time);
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every post-reset edge is a transaction to score.
  always @(posedge clk) begin
    exp_t mx;
    #1;
    if (rst_n && q.size() > 0) begin
      mx = q.pop_front();
      check("an_a", 32'(an_a), 32'(mx.an[0]));
      check("seg_a", 32'(seg_a), 32'(mx.seg[0]));
      check("frame_done_a", 32'(fd_a), 32'(mx.fd[0]));
      check("pending_a", 32'(pend_a), 32'(mx.pd[0]));
      check("an_b", 32'(an_b), 32'(mx.an[1]));
      check("seg_b", 32'(seg_b), 32'(mx.seg[1]));
      check("frame_done_b", 32'(fd_b), 32'(mx.fd[1]));
      check("pending_b", 32'(pend_b), 32'(mx.pd[1]));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    do_reset();
    idle(64);
    step(1'b1, 32'h76543210, 8'hFF);
    idle(70);
    idle_until(5);
    step(1'b1, 32'hA5A5A5A5, 8'hFF);
    idle(6);
    step(1'b1, 32'hFFFFFFFF, 8'hFF);
    idle(70);
    idle_until(31);
    step(1'b1, 32'h000000A0, 8'h02);
    idle(40);
    for (int r = 0; r < 300; r++) begin
      step($urandom_range(0, 7) == 0, $urandom, 8'($urandom));
    end
    idle_until(2);
    step(1'b1, 32'h12345678, 8'hFF);
    idle_until(13);
    do_reset();
    idle(64);
    @(posedge clk);
    #2;
    check("queue_drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
